// File: rtl/prbs5_checker.sv
// Receive-side checker for the x^5+x^3+1 Fibonacci LFSR word stream.
// Hunts for the sequence, locks after LOCK_CNT predicted words, then counts mismatches against a free-running reference.
module prbs5_checker #(
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       in_data,
    input  logic             err_clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             zero_flag
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_ERRS);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    // Handshake: in_data is consumed on every rising edge where in_valid=1; there is no backpressure.
    logic [1:0] state, state_nxt;
    logic [4:0] ref_q, ref_nxt, exp_w;
    logic [3:0] match_cnt, match_nxt, match_inc;
    logic [3:0] bad_cnt, bad_nxt, bad_inc;
    logic       hit_err;

    always_comb begin
        exp_w     = {ref_q[3:0], ref_q[4] ^ ref_q[2]};
        match_inc = match_cnt + 4'd1;
        bad_inc   = bad_cnt + 4'd1;
        state_nxt = state;
        ref_nxt   = ref_q;
        match_nxt = match_cnt;
        bad_nxt   = bad_cnt;
        hit_err   = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (in_data != 5'd0) begin
                        ref_nxt   = in_data;
                        match_nxt = 4'd0;
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (in_data == 5'd0) begin
                        state_nxt = HUNT;
                    end else if (in_data == exp_w) begin
                        ref_nxt   = in_data;
                        match_nxt = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_nxt = LOCKED;
                            bad_nxt   = 4'd0;
                        end
                    end else begin
                        // Reseed from the received word so a late start still converges.
                        ref_nxt   = in_data;
                        match_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    ref_nxt = exp_w;
                    if (in_data == exp_w) begin
                        bad_nxt = 4'd0;
                    end else begin
                        hit_err = 1'b1;
                        bad_nxt = bad_inc;
                        if (bad_inc == UNLOCK_N) begin
                            state_nxt = HUNT;
                            match_nxt = 4'd0;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            ref_q     <= 5'd0;
            match_cnt <= 4'd0;
            bad_cnt   <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            ref_q     <= ref_nxt;
            match_cnt <= match_nxt;
            bad_cnt   <= bad_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= hit_err;
            zero_flag <= in_valid && (in_data == 5'd0);
            if (err_clear) begin
                err_count <= hit_err ? ERR_ONE : '0;
            end else if (hit_err && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_ONE;
            end
        end
    end

endmodule

// File: doc/prbs5_checker.md
Name: prbs5_checker

Overview:
- Downstream consumer of the 5-bit Fibonacci LFSR word stream (taps x^5+x^3+1; next = {d[3:0], d[4]^d[2]}).
- Acquires lock on the incoming sequence, then runs a free-running reference and compares each valid word against it.
- Reports lock status, per-word error pulses, a saturating error count and the all-zero lockup word.
- Used as the pattern checker at the receive end of the PRBS test path.

Parameters:
- LOCK_CNT, 4, consecutive correct predictions needed to enter LOCKED (1..15).
- UNLOCK_ERRS, 3, consecutive mismatches in LOCKED that force return to HUNT (1..15).
- ERR_W, 16, width of err_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is a sample this cycle
- in_data  input  5  LFSR word under test
- err_clear  input  1  clears err_count
- locked  output  1  high while state is LOCKED
- err_pulse  output  1  one-cycle pulse per mismatched word in LOCKED
- err_count  output  ERR_W  saturating mismatch count
- zero_flag  output  1  one-cycle pulse when a valid all-zero word is received

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered.
- Reset values: locked=0, err_pulse=0, err_count=0, zero_flag=0. Internal reset: state=HUNT, ref=0, match_cnt=0, bad_cnt=0.
- Prediction: exp = {ref[3:0], ref[4]^ref[2]}.
- Cycles with in_valid=0 hold all state and counters. err_pulse and zero_flag are 0 on those cycles.
- zero_flag: asserts the cycle after any valid in_data==0, in every state.
- HUNT:
  - On a valid nonzero word: ref<=in_data, match_cnt<=0, go to SYNC.
  - A zero word leaves the state in HUNT.
- SYNC:
  - Valid word == exp: ref<=in_data, match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCKED and set bad_cnt<=0.
  - Valid nonzero word != exp: ref<=in_data (reseed), match_cnt<=0, stay in SYNC.
  - Valid zero word: go to HUNT.
  - No errors are counted in SYNC.
- LOCKED:
  - Every valid word: ref<=exp. The reference free-runs, so a single corrupted word produces exactly one error.
  - Match: bad_cnt<=0.
  - Mismatch (a zero word counts as a mismatch): err_pulse=1 next cycle, err_count increments, bad_cnt++.
  - When bad_cnt reaches UNLOCK_ERRS: go to HUNT, locked=0 next cycle, match_cnt<=0.
- locked timing:
  - Rises the cycle after the LOCK_CNT-th matching word is accepted.
  - Falls the cycle after the UNLOCK_ERRS-th consecutive mismatch is accepted.
- err_count saturates at 2^ERR_W-1.
  - err_clear alone: err_count<=0 next cycle.
  - err_clear coincident with a counted error: err_count<=1.
- rst overrides everything, including mid-lock and coincident err_clear/in_valid.
- Lock latency from the first valid word: LOCK_CNT+1 accepted words.

Test Plan:
- Lock acquisition: rst, then continuous valid 01,02,04,09,12 (LOCK_CNT=4) -> locked=1 the cycle after 12 is accepted; err_count=0, no err_pulse.
- Single-word error: locked; send 1F in place of 05, then 0B,16 -> exactly one err_pulse, err_count=1, locked stays 1.
- Loss of lock: locked; send 3 consecutive wrong words (1F,1F,1F) -> 3 err_pulses, err_count=3, locked=0 after the third. Resend 01,02,04,09,12 -> relock.
- Valid gaps: lock sequence with in_valid low for 1-3 cycles between words -> same lock result as the no-gap case, no spurious pulses.
- Zero word: in SYNC, send 00 -> zero_flag pulse, state returns to HUNT, no lock. In LOCKED, 00 -> zero_flag and err_pulse together.
- Counter edges:
  - ERR_W=2 with 5 errors -> err_count saturates at 3.
  - err_clear with a simultaneous error -> err_count=1.
  - rst while locked -> all outputs 0 the next cycle.
